// File: rtl/tx_sched.sv
// tx_sched: picks FCT, host or NULL fill characters for tx_top.
// Optional time-code source enabled by defining TX_TIMECODE_EN.
module tx_sched #(
   parameter int CREDIT_STEP  = 8,
   parameter int CREDIT_MAX   = 56,
   parameter int FCT_PEND_MAX = 7
) (
   input  logic       txClk,
   input  logic       txReset_n,
   input  logic       enable_i,
   input  logic       fct_req_i,
   input  logic       fct_rx_i,
   input  logic [7:0] hdat_i,
   input  logic       hlchar_i,
   input  logic       hvalid_i,
   output logic       hready_o,
   output logic [7:0] dat_o,
   output logic       lchar_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic [5:0] credit_o,
   output logic [2:0] fct_pend_o,
   output logic       credit_err_o
`ifdef TX_TIMECODE_EN
   ,
   input  logic [7:0] tc_i,
   input  logic       tc_valid_i,
   output logic       tc_ready_o
`endif
);

   typedef enum logic [1:0] {
      S_OFF,
      S_PICK,
      S_WAIT
   } state_e;

   localparam logic [7:0] ESC   = 8'h03;
   localparam logic [7:0] FCT   = 8'h00;
   localparam logic [6:0] STEP7 = 7'(CREDIT_STEP);
   localparam logic [6:0] MAX7  = 7'(CREDIT_MAX);
   localparam logic [2:0] PMAX  = 3'(FCT_PEND_MAX);

   state_e     state_q, state_d;
   logic [7:0] dat_q, dat_d;
   logic       lchar_q, lchar_d;
   logic       valid_q, valid_d;
   logic       sec_q, sec_d;
   logic [7:0] sec_dat_q, sec_dat_d;
   logic       sec_lchar_q, sec_lchar_d;
   logic [5:0] credit_q, credit_d;
   logic [2:0] pend_q, pend_d;
   logic       err_q, err_d;
   logic [6:0] csum;
   logic       host_load;
   logic       fct_load;
   logic       tc_take;

   // Character selection and output-register handshake FSM
   always_comb begin
      state_d     = state_q;
      dat_d       = dat_q;
      lchar_d     = lchar_q;
      valid_d     = valid_q;
      sec_d       = sec_q;
      sec_dat_d   = sec_dat_q;
      sec_lchar_d = sec_lchar_q;
      host_load   = 1'b0;
      fct_load    = 1'b0;
      tc_take     = 1'b0;
      unique case (state_q)
         S_OFF: begin
            valid_d = 1'b0;
            if (enable_i) state_d = S_PICK;
         end
         S_PICK: begin
            if (!enable_i) begin
               state_d = S_OFF;
            end else begin
               state_d = S_WAIT;
               valid_d = 1'b1;
`ifdef TX_TIMECODE_EN
               if (tc_valid_i) begin
                  dat_d       = ESC;
                  lchar_d     = 1'b1;
                  sec_d       = 1'b1;
                  sec_dat_d   = tc_i;
                  sec_lchar_d = 1'b0;
                  tc_take     = 1'b1;
               end else
`endif
               if (pend_q != 3'd0) begin
                  dat_d    = FCT;
                  lchar_d  = 1'b1;
                  fct_load = 1'b1;
               end else if (hvalid_i && credit_q != 6'd0) begin
                  dat_d     = hdat_i;
                  lchar_d   = hlchar_i;
                  host_load = 1'b1;
               end else begin
                  dat_d       = ESC;
                  lchar_d     = 1'b1;
                  sec_d       = 1'b1;
                  sec_dat_d   = FCT;
                  sec_lchar_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (valid_q && ready_i) begin
               if (sec_q) begin
                  dat_d   = sec_dat_q;
                  lchar_d = sec_lchar_q;
                  sec_d   = 1'b0;
               end else begin
                  valid_d = 1'b0;
                  state_d = enable_i ? S_PICK : S_OFF;
               end
            end
         end
         default: state_d = S_OFF;
      endcase
   end

   // Credit and owed-FCT counters with saturation error flag
   always_comb begin
      csum     = {1'b0, credit_q} + (fct_rx_i ? STEP7 : 7'd0)
                 - {6'd0, host_load};
      err_d    = err_q;
      credit_d = csum[5:0];
      if (csum > MAX7) begin
         credit_d = MAX7[5:0];
         err_d    = 1'b1;
      end
      pend_d = pend_q;
      if (fct_req_i && !fct_load) begin
         if (pend_q == PMAX) err_d = 1'b1;
         else pend_d = pend_q + 3'd1;
      end else if (!fct_req_i && fct_load) begin
         pend_d = pend_q - 3'd1;
      end
   end

   // State, output register and counter storage
   always_ff @(posedge txClk or negedge txReset_n) begin
      if (!txReset_n) begin
         state_q     <= S_OFF;
         dat_q       <= 8'd0;
         lchar_q     <= 1'b0;
         valid_q     <= 1'b0;
         sec_q       <= 1'b0;
         sec_dat_q   <= 8'd0;
         sec_lchar_q <= 1'b0;
         credit_q    <= 6'd0;
         pend_q      <= 3'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dat_q       <= dat_d;
         lchar_q     <= lchar_d;
         valid_q     <= valid_d;
         sec_q       <= sec_d;
         sec_dat_q   <= sec_dat_d;
         sec_lchar_q <= sec_lchar_d;
         credit_q    <= credit_d;
         pend_q      <= pend_d;
         err_q       <= err_d;
      end
   end

   assign hready_o     = host_load;
   assign dat_o        = dat_q;
   assign lchar_o      = lchar_q;
   assign valid_o      = valid_q;
   assign credit_o     = credit_q;
   assign fct_pend_o   = pend_q;
   assign credit_err_o = err_q;
`ifdef TX_TIMECODE_EN
   assign tc_ready_o   = tc_take;
`endif

endmodule
